xform_sequencer: RTL and testbench

//  Block-transform controller: on one command, walks a contiguous range of the 16x19 data memory and

---
 rtl/xseq_pkg.sv | 25 ++
 rtl/xseq_wait_ctr.sv | 35 +++
 rtl/xform_sequencer.sv | 160 ++++++++++++++++
 tb/tb_xform_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xseq_pkg.sv
// xseq_pkg: shared definitions for the block-transform sequencer.
//   DATA_W / ADDR_W : default data word and data-memory address widths
//   op_t            : command opcodes (encr, decr, fft, illegal)
//   state_t         : sequencer FSM states
package xseq_pkg;

   localparam int unsigned DATA_W = 19;
   localparam int unsigned ADDR_W = 4;

   typedef enum logic [1:0] {
      OP_ENCR = 2'b00,
      OP_DECR = 2'b01,
      OP_FFT  = 2'b10,
      OP_ILL  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_XFORM,
      S_WRITE,
      S_DONE
   } state_t;

endpackage

// File: rtl/xseq_wait_ctr.sv
// xseq_wait_ctr: saturating count of consecutive cycles the sequencer has
// been held off the memory port; raises fire once MAX_WAIT is reached.
// Only instantiated when XSEQ_STARVE_GUARD_EN is defined.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   hold       : sequencer wanted the port this cycle but yielded
//   clear      : sequencer was granted the port this cycle
//   fire       : held for MAX_WAIT cycles; the next access is forced
module xseq_wait_ctr #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic hold,
   input  logic clear,
   output logic fire
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (hold && (cnt != CW'(MAX_WAIT))) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign fire = (cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/xform_sequencer.sv
// xform_sequencer: on one command, walks a contiguous (wrapping) range of the
// data memory, pushes each word through encr/decr/fft and writes the result
// back in place. The CPU has priority on the shared memory port; the
// sequencer yields whenever cpu_mem_req is high.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_op/cmd_base/cmd_len    : opcode, first address, word count (0..2**AW)
//   cpu_mem_req                : CPU uses the memory port this cycle
//   cpu_stall                  : CPU freeze while a starved access is forced
//   seq_grant                  : sequencer owns the memory port this cycle
//   mem_addr/read/write/wdata  : memory port drive (valid when granted)
//   mem_rdata                  : combinational read data
//   unit_a, encr_en/decr_en/fft_en : operand and one-hot unit select (XFORM)
//   unit_result                : combinational result of the selected unit
//   busy, done, err            : status; done/err are one-cycle pulses
//   words_done                 : words written back in the current command
// Build option: define XSEQ_STARVE_GUARD_EN to enable the starvation guard
// (after MAX_WAIT consecutive yielded cycles the next access is forced and
// cpu_stall asserted). Without it cpu_stall is 0 and the sequencer waits.
module xform_sequencer
   import xseq_pkg::*;
#(
   parameter int unsigned DW       = DATA_W,
   parameter int unsigned AW       = ADDR_W,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_base,
   input  logic [AW:0]   cmd_len,
   input  logic          cpu_mem_req,
   output logic          cpu_stall,
   output logic          seq_grant,
   output logic [AW-1:0] mem_addr,
   output logic          mem_read,
   output logic          mem_write,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] unit_a,
   output logic          encr_en,
   output logic          decr_en,
   output logic          fft_en,
   input  logic [DW-1:0] unit_result,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_done
);

   if (MAX_WAIT < 1) begin : g_max_wait_check
      $error("xform_sequencer: MAX_WAIT must be at least 1");
   end

   state_t        state;
   op_t           op;
   logic [AW-1:0] cur;
   logic [AW:0]   len;
   // One data register: holds the read word in XFORM, then the unit result in WRITE.
   logic [DW-1:0] data;

   logic          active;
   logic          grant;
   logic          fire;
   logic [AW:0]   next_words;

   assign active     = (state == S_READ) || (state == S_WRITE);
   assign grant      = active && (!cpu_mem_req || fire);
   assign next_words = words_done + 1'b1;

`ifdef XSEQ_STARVE_GUARD_EN
   xseq_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_ctr (
      .clk   (clk),
      .reset (reset),
      .hold  (active && !grant),
      .clear (grant),
      .fire  (fire)
   );
   assign cpu_stall = active && fire;
`else
   assign fire      = 1'b0;
   assign cpu_stall = 1'b0;
`endif

   assign seq_grant = grant;
   assign mem_read  = grant && (state == S_READ);
   assign mem_write = grant && (state == S_WRITE);
   assign mem_addr  = grant ? cur : '0;
   assign mem_wdata = (grant && (state == S_WRITE)) ? data : '0;

   assign unit_a    = (state == S_XFORM) ? data : '0;
   assign encr_en   = (state == S_XFORM) && (op == OP_ENCR);
   assign decr_en   = (state == S_XFORM) && (op == OP_DECR);
   assign fft_en    = (state == S_XFORM) && (op == OP_FFT);

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         op         <= OP_ENCR;
         cur        <= '0;
         len        <= '0;
         data       <= '0;
         words_done <= '0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op         <= op_t'(cmd_op);
                  cur        <= cmd_base;
                  len        <= cmd_len;
                  words_done <= '0;
                  // Illegal op pulses err while staying in IDLE.
                  if (op_t'(cmd_op) == OP_ILL) begin
                     err <= 1'b1;
                  end else if (cmd_len == '0) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (grant) begin
                  data  <= mem_rdata;
                  state <= S_XFORM;
               end
            end
            S_XFORM: begin
               data  <= unit_result;
               state <= S_WRITE;
            end
            S_WRITE: begin
               if (grant) begin
                  words_done <= next_words;
                  cur        <= cur + 1'b1;
                  state      <= (next_words == len) ? S_DONE : S_READ;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xform_sequencer.sv
// tb_xform_sequencer: directed bench with a memory model, unit models and a
// write-back scoreboard for xform_sequencer.
module tb_xform_sequencer;
   import xseq_pkg::*;

   localparam int DW = 19;
   localparam int AW = 4;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_base;
   logic [AW:0]   cmd_len;
   logic          cpu_mem_req;
   logic          cpu_stall;
   logic          seq_grant;
   logic [AW-1:0] mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] unit_a;
   logic          encr_en;
   logic          decr_en;
   logic          fft_en;
   logic [DW-1:0] unit_result;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   words_done;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] old;
   } wr_t;

   logic [DW-1:0] mem     [16];
   logic [DW-1:0] ref_mem [16];
   wr_t           exp_q[$];
   int            total = 0;
   int            bad   = 0;
   int            n_reads = 0;

   xform_sequencer #(
      .DW       (DW),
      .AW       (AW),
      .MAX_WAIT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_base    (cmd_base),
      .cmd_len     (cmd_len),
      .cpu_mem_req (cpu_mem_req),
      .cpu_stall   (cpu_stall),
      .seq_grant   (seq_grant),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .unit_a      (unit_a),
      .encr_en     (encr_en),
      .decr_en     (decr_en),
      .fft_en      (fft_en),
      .unit_result (unit_result),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .words_done  (words_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] f_encr(input logic [DW-1:0] a);
      return a ^ 19'h5A5A5;
   endfunction
   function automatic logic [DW-1:0] f_decr(input logic [DW-1:0] a);
      return a ^ 19'h3C3C3;
   endfunction
   function automatic logic [DW-1:0] f_fft(input logic [DW-1:0] a);
      return {a[DW-2:0], a[DW-1]} + 19'd7;
   endfunction
   function automatic logic [DW-1:0] xf(input op_t op, input logic [DW-1:0] a);
      case (op)
         OP_ENCR: return f_encr(a);
         OP_DECR: return f_decr(a);
         default: return f_fft(a);
      endcase
   endfunction

   // Memory and unit models around the DUT.
   assign mem_rdata   = mem[mem_addr];
   assign unit_result = encr_en ? f_encr(unit_a) :
                        decr_en ? f_decr(unit_a) :
                        fft_en  ? f_fft(unit_a)  : '0;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Port monitor: contention rule and write-back scoreboard.
   always @(negedge clk) begin : mon
      wr_t w;
      if (mem_read) n_reads++;
      if (cpu_mem_req) chk("contend", {31'd0, seq_grant | mem_read | mem_write}, {31'd0, cpu_stall});
      if (mem_write) begin
         chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("wr_addr_data", {9'd0, mem_addr, mem_wdata}, {9'd0, w.addr, w.data});
         end
      end
   end

   task automatic push_exp(input op_t op, input logic [AW-1:0] base, input logic [AW:0] len);
      wr_t w;
      logic [AW-1:0] a;
      for (int unsigned i = 0; i < len; i++) begin
         a      = base + AW'(i);
         w.addr = a;
         w.old  = ref_mem[a];
         w.data = xf(op, ref_mem[a]);
         ref_mem[a] = w.data;
         exp_q.push_back(w);
      end
   endtask

   // Called #1 after a clock edge. req_s/req_n: cycles (1 = first after accept)
   // with cpu_mem_req held high.
   task automatic run_cmd(input string tag, input op_t op, input logic [AW-1:0] base,
                          input logic [AW:0] len, input int req_s, input int req_n,
                          input int exp_lat, input int exp_stall);
      int cyc;
      int stall_cyc;
      push_exp(op, base, len);
      chk({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_base  = base;
      cmd_len   = len;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cyc       = 1;
      stall_cyc = 0;
      forever begin
         cpu_mem_req = (cyc >= req_s) && (cyc < req_s + req_n);
         #0;
         if (cpu_stall && stall_cyc == 0) stall_cyc = cyc;
         if (done || cyc >= exp_lat + 40) break;
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_words_done"}, {27'd0, words_done}, {27'd0, len});
      chk({tag, "_stall_cycle"}, stall_cyc, exp_stall);
      cpu_mem_req = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_all_written"}, exp_q.size(), 0);
   endtask

   initial begin
      int   rd0;
      wr_t  w;
      reset       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_base    = '0;
      cmd_len     = '0;
      cpu_mem_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem[i]     = DW'($urandom);
         ref_mem[i] = mem[i];
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_outputs", {25'd0, busy, done, err, seq_grant, mem_read, mem_write, cpu_stall}, 32'd0);
      chk("rst_words_done", {27'd0, words_done}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Uncontended encr over 2,3,4: done 10 cycles after accept
      run_cmd("encr_b2_l3", OP_ENCR, 4'd2, 5'd3, 0, 0, 10, 0);
      // fft across the wrap: 14,15,0,1
      run_cmd("fft_wrap", OP_FFT, 4'd14, 5'd4, 0, 0, 13, 0);
      // CPU holds the port 5 cycles during the second READ
      run_cmd("decr_contend", OP_DECR, 4'd5, 5'd2, 4, 5, 12, 0);
      // Full-depth command
      run_cmd("encr_full", OP_ENCR, 4'd7, 5'd16, 0, 0, 49, 0);

      // Illegal op: err pulse only, no memory traffic
      rd0       = n_reads;
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_base  = 4'd0;
      cmd_len   = 5'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("ill_err_pulse", {30'd0, err, busy}, 32'd2);
      @(posedge clk); #1;
      chk("ill_err_cleared", {30'd0, err, busy}, 32'd0);
      chk("ill_no_reads", n_reads, rd0);

      // Zero length: done pulse on the cycle after accept
      run_cmd("len0", OP_ENCR, 4'd3, 5'd0, 0, 0, 1, 0);
      chk("len0_no_reads", n_reads, rd0);

      // Reset mid-command after the first write-back
      push_exp(OP_ENCR, 4'd0, 5'd4);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_base  = 4'd0;
      cmd_len   = 5'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_pending", exp_q.size(), 3);
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_state", {25'd0, cmd_ready, busy, done, seq_grant, mem_read, mem_write, err}, 32'h40);
      end
      chk("midrst_words_done", {27'd0, words_done}, 32'd0);
      reset = 1'b1;
      while (exp_q.size() != 0) begin
         w = exp_q.pop_front();
         ref_mem[w.addr] = w.old;
      end
      repeat (4) begin
         @(posedge clk); #1;
         chk("midrst_no_done", {30'd0, done, busy}, 32'd0);
      end

      // Long CPU hold over READ and WRITE
`ifdef XSEQ_STARVE_GUARD_EN
      run_cmd("long_hold", OP_DECR, 4'd8, 5'd1, 1, 20, 20, 9);
`else
      run_cmd("long_hold", OP_DECR, 4'd8, 5'd1, 1, 20, 24, 0);
`endif

      for (int i = 0; i < 16; i++) begin
         chk($sformatf("mem_final_%0d", i), {13'd0, mem[i]}, {13'd0, ref_mem[i]});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
